// File: rtl/spi_keys_rx.sv
// rtl/spi_keys_rx.sv - SPI mode-0 slave collecting key-state frames (optional SPI_KEYS_RX_EDGE_EN edge pulses)
module spi_keys_rx #(
   parameter int NUM_KEYS       = 61,
   parameter int ACK_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk_g_i,
   input  logic                rstn_g_i,
   input  logic                spi_clk_i,
   input  logic                spi_mosi_i,
   output logic                spi_keys_ack_o,
   output logic [NUM_KEYS-1:0] keys_o,
   output logic                keys_valid_o,
   output logic                frame_err_o,
   output logic [NUM_KEYS-1:0] keys_pressed_o,
   output logic [NUM_KEYS-1:0] keys_released_o
);

   localparam int GROUPS = (NUM_KEYS + 7) / 8;
   localparam int GW     = $clog2(GROUPS + 1);
   localparam int FW     = GROUPS * 8;
   localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int AW     = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_ACK} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_sck_s1, r_sck_s2, r_sck_d;
   logic                r_mosi_s1, r_mosi_s2;
   logic [6:0]          r_shift;
   logic [2:0]          r_bit_cnt;
   logic [GW-1:0]       r_byte_cnt;
   logic [TW-1:0]       r_to_cnt;
   logic [AW-1:0]       r_ack_cnt;
   logic [FW-1:0]       r_frame;
   logic                r_keys_valid, r_frame_err, r_ack;
   logic [NUM_KEYS-1:0] r_keys;

   logic                w_edge;
   logic [7:0]          w_byte;
   logic                w_byte_done, w_frame_done, w_timeout, w_overrun, w_ack_end;
   logic [FW-1:0]       w_frame_next;

   // Double-flop SCK/MOSI into clk_g_i and keep one SCK history flop for edge detection
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) begin
         r_sck_s1  <= 1'b0;
         r_sck_s2  <= 1'b0;
         r_sck_d   <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_sck_s1  <= spi_clk_i;
         r_sck_s2  <= r_sck_s1;
         r_sck_d   <= r_sck_s2;
         r_mosi_s1 <= spi_mosi_i;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   assign w_edge = r_sck_s2 & ~r_sck_d;
   assign w_byte = {r_shift, r_mosi_s2};

   // State register
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_edge) w_state_nxt = S_RECV;
         S_RECV: begin
            if (w_frame_done)   w_state_nxt = S_ACK;
            else if (w_timeout) w_state_nxt = S_IDLE;
         end
         S_ACK:  if (w_ack_end) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Per-state event decode; a bit arriving on the expiry cycle wins over the timeout
   always_comb begin
      w_byte_done  = (r_state != S_ACK) && w_edge && (r_bit_cnt == 3'd7);
      w_frame_done = (r_state == S_RECV) && w_byte_done && (r_byte_cnt == GW'(GROUPS - 1));
      w_timeout    = (r_state == S_RECV) && !w_edge && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
      w_overrun    = (r_state == S_ACK) && w_edge;
      w_ack_end    = (r_state == S_ACK) && (r_ack_cnt == AW'(ACK_CYCLES - 1));
      w_frame_next = r_frame;
      for (int g = 0; g < GROUPS; g++) begin
         if (r_byte_cnt == GW'(g)) w_frame_next[g*8 +: 8] = w_byte;
      end
   end

   // Shift register, bit/byte counters, timeout and ack counters, frame buffer
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_to_cnt   <= '0;
         r_ack_cnt  <= '0;
         r_frame    <= '0;
      end else begin
         if (w_edge && (r_state != S_ACK)) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_byte_done) begin
            r_frame    <= w_frame_next;
            r_byte_cnt <= r_byte_cnt + GW'(1);
         end
         if (r_state == S_RECV && !w_edge) begin
            if (r_to_cnt != TW'(TIMEOUT_CYCLES - 1)) r_to_cnt <= r_to_cnt + TW'(1);
         end else begin
            r_to_cnt <= '0;
         end
         if (w_timeout || r_state == S_ACK) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
         end
         if (r_state == S_ACK) r_ack_cnt <= r_ack_cnt + AW'(1);
         else                  r_ack_cnt <= '0;
      end
   end

   // Registered outputs: frame publish, status pulses, ack level
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) begin
         r_keys       <= '1;
         r_keys_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_ack        <= 1'b0;
      end else begin
         if (w_frame_done) r_keys <= w_frame_next[NUM_KEYS-1:0];
         r_keys_valid <= w_frame_done;
         r_frame_err  <= w_timeout | w_overrun;
         r_ack        <= (w_state_nxt == S_ACK);
      end
   end

   assign keys_o         = r_keys;
   assign keys_valid_o   = r_keys_valid;
   assign frame_err_o    = r_frame_err;
   assign spi_keys_ack_o = r_ack;

`ifdef SPI_KEYS_RX_EDGE_EN
   logic [NUM_KEYS-1:0] r_prev, r_pressed, r_released;

   // Compare each published frame against the previous one for press/release pulses
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) begin
         r_prev     <= '1;
         r_pressed  <= '0;
         r_released <= '0;
      end else if (w_frame_done) begin
         r_prev     <= w_frame_next[NUM_KEYS-1:0];
         r_pressed  <= r_prev & ~w_frame_next[NUM_KEYS-1:0];
         r_released <= ~r_prev & w_frame_next[NUM_KEYS-1:0];
      end else begin
         r_pressed  <= '0;
         r_released <= '0;
      end
   end

   assign keys_pressed_o  = r_pressed;
   assign keys_released_o = r_released;
`else
   assign keys_pressed_o  = '0;
   assign keys_released_o = '0;
`endif

endmodule

// File: tb/tb_spi_keys_rx.sv
// tb/tb_spi_keys_rx.sv - scoreboard bench for spi_keys_rx
module tb_spi_keys_rx;

   localparam int NK = 61;

   typedef struct {
      bit          is_err;
      logic [NK-1:0] keys;
      logic [NK-1:0] pr;
      logic [NK-1:0] rl;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sck = 1'b0;
   logic          mosi = 1'b0;
   logic          ack;
   logic [NK-1:0] keys, pressed, released;
   logic          valid, err;

   int            n_pass = 0;
   int            n_total = 0;
   int            n_valid = 0;
   int            ack_run = 0;
   exp_t          sb[$];
   logic [NK-1:0] model_prev = '1;
   logic [NK-1:0] last_keys = '1;

   spi_keys_rx #(.NUM_KEYS(NK), .ACK_CYCLES(16), .TIMEOUT_CYCLES(1024)) dut (
      .clk_g_i(clk), .rstn_g_i(rst_n), .spi_clk_i(sck), .spi_mosi_i(mosi),
      .spi_keys_ack_o(ack), .keys_o(keys), .keys_valid_o(valid), .frame_err_o(err),
      .keys_pressed_o(pressed), .keys_released_o(released));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_valid(input logic [NK-1:0] k);
      exp_t e;
      e.is_err = 1'b0;
      e.keys   = k;
`ifdef SPI_KEYS_RX_EDGE_EN
      e.pr = model_prev & ~k;
      e.rl = ~model_prev & k;
`else
      e.pr = '0;
      e.rl = '0;
`endif
      model_prev = k;
      last_keys  = k;
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.keys   = last_keys;
      e.pr     = '0;
      e.rl     = '0;
      sb.push_back(e);
   endtask

   // Bits go MSB first within each byte, byte 0 first; last rise delayed by last_gap clocks
   task automatic send_bits(input logic [63:0] f, input int nbits, input int last_gap);
      for (int k = 0; k < nbits; k++) begin
         mosi = f[8*(k/8) + 7 - (k%8)];
         if (k == nbits - 1) tick(last_gap - 2);
         else                tick(2);
         sck = 1'b1;
         tick(2);
         sck = 1'b0;
      end
   endtask

   task automatic wait_ack_cycle(input string nm);
      int t = 0;
      while (!ack && t < 100) begin tick(1); t++; end
      if (t >= 100) chk({nm, "_ack_rise_timeout"}, 64'(ack), 64'd1);
      t = 0;
      while (ack && t < 100) begin tick(1); t++; end
      if (t >= 100) chk({nm, "_ack_fall_timeout"}, 64'(ack), 64'd0);
      tick(2);
   endtask

   // Scoreboard monitor: pops one expectation per output pulse
   always @(negedge clk) begin
      if (rst_n && (valid || err)) begin
         if (valid && err) chk("valid_err_same_cycle", 64'(valid & err), 64'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse_sb_size", 64'(sb.size()), 64'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_kind_is_err", 64'(err), 64'(e.is_err));
            chk("keys_o", 64'(keys), 64'(e.keys));
            chk("keys_pressed_o", 64'(pressed), 64'(e.pr));
            chk("keys_released_o", 64'(released), 64'(e.rl));
            if (valid) n_valid++;
         end
      end
   end

   // Ack pulse-width monitor
   always @(negedge clk) begin
      if (!rst_n) ack_run = 0;
      else if (ack) ack_run++;
      else if (ack_run != 0) begin
         chk("ack_high_cycles", 64'(ack_run), 64'd16);
         ack_run = 0;
      end
   end

   initial begin
      tick(3);
      chk("rst_keys", 64'(keys), 64'h1FFF_FFFF_FFFF_FFFF);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      tick(4);

      // T1: key 0 low
      push_valid(61'h1FFF_FFFF_FFFF_FFFE);
      send_bits(64'hFFFF_FFFF_FFFF_FFFE, 64, 4);
      wait_ack_cycle("t1");

      // T2: partial frame times out, then a clean frame
      push_err();
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 24, 4);
      tick(1100);
      push_valid(61'h10DE_BC9A_7856_3412);
      send_bits(64'hF0DE_BC9A_7856_3412, 64, 4);
      wait_ack_cycle("t2");

      // Last bit lands exactly on the timeout expiry cycle: still a bit
      push_valid(61'h1F11_1111_1111_1111);
      send_bits(64'h1F11_1111_1111_1111, 64, 1024);
      wait_ack_cycle("t2b");

      // T3: SCK edge during ACK is an overrun
      push_valid(61'h05A5_A5A5_A5A5_A5A5);
      push_err();
      send_bits(64'hA5A5_A5A5_A5A5_A5A5, 64, 4);
      begin
         int t = 0;
         while (!ack && t < 100) begin tick(1); t++; end
      end
      tick(2);
      sck = 1'b1;
      tick(2);
      sck = 1'b0;
      wait_ack_cycle("t3");

      // T4: reset after 20 bits, then a clean frame
      send_bits(64'h0000_0000_0000_5A3C, 20, 4);
      rst_n = 1'b0;
      tick(3);
      chk("midreset_keys", 64'(keys), 64'h1FFF_FFFF_FFFF_FFFF);
      chk("midreset_ack", 64'(ack), 64'd0);
      model_prev = '1;
      last_keys  = '1;
      rst_n = 1'b1;
      tick(4);
      push_valid(61'h0807_0605_0403_0201);
      send_bits(64'h0807_0605_0403_0201, 64, 4);
      wait_ack_cycle("t4");

      // T5: key 5 pressed then released, back to back
      push_valid(61'h1FFF_FFFF_FFFF_FFDF);
      send_bits(64'hFFFF_FFFF_FFFF_FFDF, 64, 4);
      wait_ack_cycle("t5a");
      push_valid(61'h1FFF_FFFF_FFFF_FFFF);
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64, 4);
      wait_ack_cycle("t5b");

      tick(10);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("valid_count", 64'(n_valid), 64'd7);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
